// File: rtl/atm_pkg.sv
// Constants shared between the button conditioner and atm_board.
package atm_pkg;
   localparam int CNT_W               = 16;
   localparam int SW_W                = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 1;
   localparam int DEF_SYNC_STAGES     = 2;
endpackage

// File: rtl/btn_conditioner_if.sv
// Raw button/switch inputs and conditioned outputs between the board and the conditioner.
interface btn_conditioner_if;
   import atm_pkg::*;

   logic            BTN3_raw;
   logic            BTN2_raw;
   logic            BTN1_raw;
   logic [SW_W-1:0] SW_raw;
   logic            BTN3;
   logic            BTN2;
   logic            BTN1;
   logic [SW_W-1:0] SW;
   logic            any_btn;

   modport master (
      output BTN3_raw, BTN2_raw, BTN1_raw, SW_raw,
      input  BTN3, BTN2, BTN1, SW, any_btn
   );

   modport slave (
      input  BTN3_raw, BTN2_raw, BTN1_raw, SW_raw,
      output BTN3, BTN2, BTN1, SW, any_btn
   );
endinterface

// File: rtl/btn_debounce.sv
// One-bit synchronizer, counting debouncer and press detector.
// rise_o is combinational; it is high in the cycle whose edge moves stable 0->1.
module btn_debounce
   import atm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic rise_o
);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   stable_q;
   logic                   stable_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   s;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
   assign s      = sync_q[SYNC_STAGES-1];

   // cnt only grows while s disagrees with stable, so it never passes CNT_TC.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      rise_o   = 1'b0;
      if (s != stable_q) begin
         if (cnt_q == CNT_TC) begin
            stable_d = s;
            rise_o   = s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/btn_conditioner.sv
// Conditions three push-buttons into one-clock press pulses and synchronizes the switches.
// Define BTN_PRIORITY_EN to keep only the highest button (BTN3 > BTN2 > BTN1) when presses coincide.
module btn_conditioner
   import atm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
   input  logic            clk,
   input  logic            rst,
   btn_conditioner_if.slave bus
);
   logic [2:0] raw;
   logic [2:0] rise;
   logic [2:0] btn_d;
   logic [2:0] btn_q;
   logic       any_d;
   logic       any_q;

   logic [SYNC_STAGES-1:0][SW_W-1:0] sw_q;
   logic [SYNC_STAGES-1:0][SW_W-1:0] sw_d;

   assign raw = {bus.BTN3_raw, bus.BTN2_raw, bus.BTN1_raw};

   for (genvar i = 0; i < 3; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .SYNC_STAGES    (SYNC_STAGES)
      ) u_deb (
         .clk   (clk),
         .rst   (rst),
         .raw_i (raw[i]),
         .rise_o(rise[i])
      );
   end

   // Suppressed presses are dropped; the debouncers still track their levels.
   always_comb begin
      btn_d = rise;
`ifdef BTN_PRIORITY_EN
      if (rise[2]) begin
         btn_d = 3'b100;
      end else if (rise[1]) begin
         btn_d = 3'b010;
      end
`else
      btn_d = rise;
`endif
      any_d = |btn_d;
   end

   assign sw_d = {sw_q[SYNC_STAGES-2:0], bus.SW_raw};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q <= '0;
         any_q <= 1'b0;
         sw_q  <= '0;
      end else begin
         btn_q <= btn_d;
         any_q <= any_d;
         sw_q  <= sw_d;
      end
   end

   assign bus.BTN3    = btn_q[2];
   assign bus.BTN2    = btn_q[1];
   assign bus.BTN1    = btn_q[0];
   assign bus.any_btn = any_q;
   assign bus.SW      = sw_q[SYNC_STAGES-1];
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench: dut_a uses D=1/S=2, dut_b uses D=4/S=2.
module tb_btn_conditioner;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   btn_conditioner_if bus_a ();
   btn_conditioner_if bus_b ();

   btn_conditioner #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );
   btn_conditioner #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {any_btn, BTN3, BTN2, BTN1}
   function automatic logic [3:0] obs(input int which);
      if (which == 0) return {bus_a.any_btn, bus_a.BTN3, bus_a.BTN2, bus_a.BTN1};
      else            return {bus_b.any_btn, bus_b.BTN3, bus_b.BTN2, bus_b.BTN1};
   endfunction

   task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance n cycles; the pulse pattern mask must appear only after tick number 'at' (0 = never).
   task automatic expect_pulse(input string tag, input int which, input int n,
                               input int at, input logic [2:0] mask);
      logic [3:0] e;
      for (int i = 1; i <= n; i++) begin
         tick(1);
         e = (i == at) ? {|mask, mask} : 4'b0000;
         chk(tag, obs(which), e);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      bus_a.BTN3_raw = 1'b0; bus_a.BTN2_raw = 1'b0; bus_a.BTN1_raw = 1'b0; bus_a.SW_raw = 4'h0;
      bus_b.BTN3_raw = 1'b0; bus_b.BTN2_raw = 1'b0; bus_b.BTN1_raw = 1'b0; bus_b.SW_raw = 4'h0;

      #2 rst = 1'b0;
      #1;
      chk("rst_btn_a", obs(0), 4'b0000);
      chk("rst_btn_b", obs(1), 4'b0000);
      chk("rst_sw_a", bus_a.SW, 4'h0);
      tick(2);
      chk("rst_hold_a", obs(0), 4'b0000);
      chk("rst_hold_b", obs(1), 4'b0000);
      rst = 1'b1;
      tick(1);

      // D=1: single-cycle raw high -> exactly one pulse two edges later.
      bus_a.BTN3_raw = 1'b1;
      tick(1);
      bus_a.BTN3_raw = 1'b0;
      expect_pulse("d1_btn3", 0, 5, 2, 3'b100);

      // Coincident presses on BTN3 and BTN1.
      bus_a.BTN3_raw = 1'b1;
      bus_a.BTN1_raw = 1'b1;
      tick(1);
      bus_a.BTN3_raw = 1'b0;
      bus_a.BTN1_raw = 1'b0;
`ifdef BTN_PRIORITY_EN
      expect_pulse("prio", 0, 5, 2, 3'b100);
`else
      expect_pulse("both", 0, 5, 2, 3'b101);
`endif

      // Single-cycle BTN2 on dut_a while priority is irrelevant.
      bus_a.BTN2_raw = 1'b1;
      tick(1);
      bus_a.BTN2_raw = 1'b0;
      expect_pulse("d1_btn2", 0, 4, 2, 3'b010);

      // Switch path: two stages, no debounce.
      bus_a.SW_raw = 4'b1001;
      tick(1);
      chk("sw_stage1", bus_a.SW, 4'b0000);
      tick(1);
      chk("sw_stage2", bus_a.SW, 4'b1001);

      // D=4: 3-cycle glitch is rejected.
      bus_b.BTN2_raw = 1'b1;
      tick(3);
      bus_b.BTN2_raw = 1'b0;
      expect_pulse("d4_glitch3", 1, 8, 0, 3'b000);

      // D=4: 4-cycle press accepted at edge k+5.
      bus_b.BTN2_raw = 1'b1;
      tick(4);
      bus_b.BTN2_raw = 1'b0;
      expect_pulse("d4_press4", 1, 8, 2, 3'b010);

      // Held 50+ cycles -> one pulse only.
      bus_b.BTN2_raw = 1'b1;
      expect_pulse("d4_hold", 1, 55, 6, 3'b010);
      bus_b.BTN2_raw = 1'b0;
      tick(10);

      // Press, short release, press again -> single pulse.
      bus_b.BTN2_raw = 1'b1;
      expect_pulse("dbl_first", 1, 10, 6, 3'b010);
      bus_b.BTN2_raw = 1'b0;
      tick(2);
      bus_b.BTN2_raw = 1'b1;
      expect_pulse("dbl_short_rel", 1, 12, 0, 3'b000);
      // Qualified release then press -> second pulse.
      bus_b.BTN2_raw = 1'b0;
      tick(4);
      bus_b.BTN2_raw = 1'b1;
      expect_pulse("dbl_second", 1, 10, 6, 3'b010);
      bus_b.BTN2_raw = 1'b0;
      tick(10);

      // Reset mid-debounce (cnt reaches 2 after the 4th edge).
      bus_b.BTN2_raw = 1'b1;
      tick(4);
      #2 rst = 1'b0;
      #1;
      chk("async_btn_a", obs(0), 4'b0000);
      chk("async_btn_b", obs(1), 4'b0000);
      chk("async_sw_a", bus_a.SW, 4'h0);
      tick(2);
      chk("rst_mid_b", obs(1), 4'b0000);
      rst = 1'b1;
      // Button still held: full re-qualification needed after reset.
      expect_pulse("rst_requal", 1, 10, 6, 3'b010);
      bus_b.BTN2_raw = 1'b0;
      tick(2);
      chk("sw_after_rst", bus_a.SW, 4'b1001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
